udp_tx: RTL and testbench

UDP/IPv4 frame builder sitting directly upstream of the MII transmitter in the network stack. Accepts a send request with a destination and payload length, then streams payload bytes in. Emits the 20-byte IPv4 header, the 8-byte UDP header and the payload as a byte stream with sop/eop framing into the MII transmitter's byte handshake. The IPv4 header checksum is computed before the first byte leaves.

---
 rtl/net_pkg.sv | 19 +
 rtl/ip_csum16.sv | 38 +++
 rtl/udp_tx.sv | 198 +++++++++++++++++++
 tb/tb_udp_tx.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_pkg.sv
// net_pkg: shared network-stack constants and types.
// Used by the UDP transmit path and the MII receive-side checks.
package net_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam int          IPV4_HDR_BYTES = 20;
  localparam int          UDP_HDR_BYTES  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSUM,
    ST_FOLD,
    ST_HDR,
    ST_PAY,
    ST_EOP
  } udp_state_t;

endpackage

// File: rtl/ip_csum16.sv
// ip_csum16: 16-bit one's-complement header checksum accumulator.
// Clear, add one word per cycle, then fold carries and invert.
module ip_csum16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        add,
  input  logic        fold,
  input  logic [15:0] word,
  output logic [15:0] csum
);

  logic [19:0] acc;
  logic [16:0] s1;
  logic [15:0] s2;

  // End-around carry: two folds always reach a 16-bit result
  always_comb begin
    s1 = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
    s2 = s1[15:0] + {15'b0, s1[16]};
  end

  // Accumulate header words, capture the inverted fold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      csum <= '0;
    end else begin
      if (clr)
        acc <= '0;
      else if (add)
        acc <= acc + {4'b0, word};
      if (fold)
        csum <= ~s2;
    end
  end

endmodule

// File: rtl/udp_tx.sv
// udp_tx: UDP/IPv4 frame builder feeding the MII byte transmitter.
// Checksums the IPv4 header, then streams header, payload and an eop beat.
module udp_tx
  import net_pkg::*;
#(
  parameter logic [31:0] P_SRC_IP      = 32'hC0A8010A,
  parameter logic [7:0]  P_TTL         = 8'h40,
  parameter int          P_MAX_PAYLOAD = 122
) (
  input  logic        tx_clk,
  input  logic        rst_n,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic [31:0] req_dst_ip,
  input  logic [47:0] req_dst_mac,
  input  logic [15:0] req_src_port,
  input  logic [15:0] req_dst_port,
  input  logic [10:0] req_len,
  output logic        req_err,
  input  logic [7:0]  pay_byte,
  input  logic        pay_vld,
  output logic        pay_rdy,
  output logic [7:0]  eth_tx_byte,
  output logic        eth_byte_vld,
  input  logic        eth_byte_rdy,
  output logic        eth_sop,
  output logic        eth_eop,
  output logic [47:0] dst_mac,
  output logic [15:0] pkt_type
);

  udp_state_t  state;
  udp_state_t  state_nxt;

  logic [4:0]  idx;
  logic [10:0] pcnt;
  logic [31:0] dst_ip_q;
  logic [15:0] src_port_q;
  logic [15:0] dst_port_q;
  logic [10:0] len_q;
  logic [47:0] mac_q;
  logic [15:0] ident;
  logic [15:0] ident_q;
  logic        err_q;

  logic        req_fire;
  logic        req_bad;
  logic        pay_fire;
  logic [3:0]  widx;
  logic [15:0] hword;
  logic [15:0] csum;
  logic [15:0] total_len;
  logic [15:0] udp_len;

  assign req_fire  = req_vld && req_rdy;
  assign req_bad   = (req_len == '0) ||
                     (req_len > 11'(P_MAX_PAYLOAD));
  assign pay_fire  = (state == ST_PAY) &&
                     pay_vld && eth_byte_rdy;
  assign total_len = 16'(IPV4_HDR_BYTES + UDP_HDR_BYTES)
                     + {5'b0, len_q};
  assign udp_len   = 16'(UDP_HDR_BYTES) + {5'b0, len_q};

  assign req_err  = err_q;
  assign dst_mac  = mac_q;
  assign pkt_type = ETHERTYPE_IPV4;

  // Header word select; checksum field reads as zero while summing
  always_comb begin
    widx  = (state == ST_HDR) ? idx[4:1] : idx[3:0];
    hword = '0;
    unique case (widx)
      4'd0:    hword = 16'h4500;
      4'd1:    hword = total_len;
      4'd2:    hword = ident_q;
      4'd3:    hword = 16'h4000;
      4'd4:    hword = {P_TTL, IP_PROTO_UDP};
      4'd5:    hword = (state == ST_HDR) ? csum : 16'h0000;
      4'd6:    hword = P_SRC_IP[31:16];
      4'd7:    hword = P_SRC_IP[15:0];
      4'd8:    hword = dst_ip_q[31:16];
      4'd9:    hword = dst_ip_q[15:0];
      4'd10:   hword = src_port_q;
      4'd11:   hword = dst_port_q;
      4'd12:   hword = udp_len;
      default: hword = '0;
    endcase
  end

  ip_csum16 u_csum (
    .clk   (tx_clk),
    .rst_n (rst_n),
    .clr   (req_fire),
    .add   (state == ST_CSUM),
    .fold  (state == ST_FOLD),
    .word  (hword),
    .csum  (csum)
  );

  // State register
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (req_fire && !req_bad)
          state_nxt = ST_CSUM;
      ST_CSUM:
        if (idx == 5'd9)
          state_nxt = ST_FOLD;
      ST_FOLD:
        state_nxt = ST_HDR;
      ST_HDR:
        if (eth_byte_rdy && idx == 5'd27)
          state_nxt = ST_PAY;
      ST_PAY:
        if (pay_fire && (pcnt + 11'd1 == len_q))
          state_nxt = ST_EOP;
      ST_EOP:
        if (eth_byte_rdy)
          state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and byte stream outputs
  always_comb begin
    req_rdy      = 1'b0;
    pay_rdy      = 1'b0;
    eth_byte_vld = 1'b0;
    eth_tx_byte  = '0;
    eth_sop      = 1'b0;
    eth_eop      = 1'b0;
    unique case (state)
      ST_IDLE: req_rdy = rst_n;
      ST_HDR: begin
        eth_byte_vld = 1'b1;
        eth_tx_byte  = idx[0] ? hword[7:0] : hword[15:8];
        eth_sop      = (idx == 5'd0);
      end
      ST_PAY: begin
        eth_byte_vld = pay_vld;
        pay_rdy      = eth_byte_rdy;
        eth_tx_byte  = pay_byte;
      end
      ST_EOP: begin
        eth_byte_vld = 1'b1;
        eth_eop      = 1'b1;
      end
      default: ;
    endcase
  end

  // Request latch, ident counter, reject pulse and frame counters
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      pcnt       <= '0;
      dst_ip_q   <= '0;
      src_port_q <= '0;
      dst_port_q <= '0;
      len_q      <= '0;
      mac_q      <= '0;
      ident      <= '0;
      ident_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= req_fire && req_bad;
      if (req_fire && !req_bad) begin
        dst_ip_q   <= req_dst_ip;
        src_port_q <= req_src_port;
        dst_port_q <= req_dst_port;
        len_q      <= req_len;
        mac_q      <= req_dst_mac;
        ident_q    <= ident;
        ident      <= ident + 16'd1;
      end
      if (state != state_nxt)
        idx <= '0;
      else if (state == ST_CSUM ||
               (state == ST_HDR && eth_byte_rdy))
        idx <= idx + 5'd1;
      if (state == ST_IDLE)
        pcnt <= '0;
      else if (pay_fire)
        pcnt <= pcnt + 11'd1;
    end
  end

endmodule

// File: tb/tb_udp_tx.sv
// tb_udp_tx: directed bench for the UDP/IPv4 frame builder.
// Hand-computed frames, checksums, idents and handshake behaviour.
module tb_udp_tx;

  logic        tx_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_dst_ip;
  logic [47:0] req_dst_mac;
  logic [15:0] req_src_port;
  logic [15:0] req_dst_port;
  logic [10:0] req_len;
  logic        req_err;
  logic [7:0]  pay_byte;
  logic        pay_vld;
  logic        pay_rdy;
  logic [7:0]  eth_tx_byte;
  logic        eth_byte_vld;
  logic        eth_byte_rdy;
  logic        eth_sop;
  logic        eth_eop;
  logic [47:0] dst_mac;
  logic [15:0] pkt_type;

  int vec = 0;
  int errs = 0;

  logic [7:0]  cap[$];
  int          sop_cnt, sop_pos, eop_pos, first_vld;
  int          rdy_early, unstable, pay_early, mac_bad;
  logic [7:0]  eop_byte;
  logic [7:0]  pay_base;
  logic [47:0] exp_mac;
  logic [7:0]  hand [32];

  udp_tx dut (
    .tx_clk       (tx_clk),
    .rst_n        (rst_n),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .req_dst_ip   (req_dst_ip),
    .req_dst_mac  (req_dst_mac),
    .req_src_port (req_src_port),
    .req_dst_port (req_dst_port),
    .req_len      (req_len),
    .req_err      (req_err),
    .pay_byte     (pay_byte),
    .pay_vld      (pay_vld),
    .pay_rdy      (pay_rdy),
    .eth_tx_byte  (eth_tx_byte),
    .eth_byte_vld (eth_byte_vld),
    .eth_byte_rdy (eth_byte_rdy),
    .eth_sop      (eth_sop),
    .eth_eop      (eth_eop),
    .dst_mac      (dst_mac),
    .pkt_type     (pkt_type)
  );

  always #5 tx_clk = ~tx_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running");
    $fatal(1);
  end

  task automatic step();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic do_reset();
    req_vld = 1'b0;
    pay_vld = 1'b0;
    rst_n   = 1'b0;
    step();
    rst_n   = 1'b1;
  endtask

  task automatic set_req(input logic [31:0] ip,
                         input logic [10:0] len);
    req_dst_ip   = ip;
    req_dst_mac  = exp_mac;
    req_src_port = 16'h1234;
    req_dst_port = 16'h5678;
    req_len      = len;
    req_vld      = 1'b1;
  endtask

  task automatic wait_accept(output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      #3;
      if (req_rdy) ok = 1'b1;
      else waited++;
      step();
    end
  endtask

  task automatic run_frame(input int len, input bit stall,
                           output bit ok);
    int pi;
    bit pv;
    bit pstall;
    logic [7:0] pb;
    pi = 0; pv = 1'b0; pstall = 1'b0; pb = '0; ok = 1'b0;
    cap.delete();
    sop_cnt = 0; sop_pos = -1; eop_pos = -1; eop_byte = '0;
    first_vld = -1; rdy_early = 0; unstable = 0;
    pay_early = 0; mac_bad = 0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      eth_byte_rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!pv && pi < len)
        pv = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      pay_vld  = pv;
      pay_byte = pay_base + 8'(pi);
      #3;
      if (eth_byte_vld && first_vld < 0) first_vld = c;
      if (pstall && (!eth_byte_vld || eth_tx_byte !== pb))
        unstable++;
      if (pay_rdy && cap.size() < 28) pay_early++;
      if (req_rdy) rdy_early++;
      if (eth_byte_vld && dst_mac !== exp_mac) mac_bad++;
      if (eth_byte_vld && eth_byte_rdy) begin
        if (eth_sop) begin
          sop_cnt++;
          sop_pos = cap.size();
        end
        if (eth_eop) begin
          eop_pos  = cap.size();
          eop_byte = eth_tx_byte;
          ok = 1'b1;
        end else begin
          cap.push_back(eth_tx_byte);
        end
      end
      pstall = eth_byte_vld && !eth_byte_rdy;
      pb = eth_tx_byte;
      if (pay_vld && pay_rdy) begin
        pi++;
        pv = 1'b0;
      end
      step();
    end
    pay_vld = 1'b0;
    eth_byte_rdy = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    vec++;
    if ({req_rdy, pay_rdy, eth_byte_vld, eth_sop, eth_eop,
         req_err} !== 6'b0) begin
      errs++;
      $display("FAIL reset_ctl: got %b want 000000",
               {req_rdy, pay_rdy, eth_byte_vld, eth_sop,
                eth_eop, req_err});
    end
    vec++;
    if (dst_mac !== 48'h0 || eth_tx_byte !== 8'h0) begin
      errs++;
      $display("FAIL reset_data: mac %h byte %h want 0",
               dst_mac, eth_tx_byte);
    end
    vec++;
    if (pkt_type !== 16'h0800) begin
      errs++;
      $display("FAIL reset_type: got %h want 0800", pkt_type);
    end
    step();
    rst_n = 1'b1;
    #3;
    vec++;
    if (req_rdy !== 1'b1) begin
      errs++;
      $display("FAIL idle_rdy: got %b want 1", req_rdy);
    end
    step();
  endtask

  task automatic test_csum_frame();
    bit ok;
    int w;
    logic [7:0] got;
    set_req(32'hC0A80101, 11'd4);
    wait_accept(ok, w);
    req_vld = 1'b0;
    vec++;
    if (!ok) begin
      errs++;
      $display("FAIL csum_accept: got timeout want accept");
    end
    run_frame(4, 1'b0, ok);
    vec++;
    if (!ok) begin
      errs++;
      $display("FAIL csum_eop: got timeout want eop");
    end
    vec++;
    if (first_vld != 11) begin
      errs++;
      $display("FAIL csum_latency: got %0d want 11", first_vld);
    end
    for (int i = 0; i < 32; i++) begin
      got = (i < cap.size()) ? cap[i] : 8'hxx;
      vec++;
      if (got !== hand[i]) begin
        errs++;
        $display("FAIL csum_byte[%0d]: got %h want %h",
                 i, got, hand[i]);
      end
    end
    vec++;
    if (sop_cnt != 1 || sop_pos != 0) begin
      errs++;
      $display("FAIL csum_sop: got cnt %0d pos %0d want 1 0",
               sop_cnt, sop_pos);
    end
    vec++;
    if (eop_pos != 32 || eop_byte !== 8'h00) begin
      errs++;
      $display("FAIL csum_eop_pos: got %0d/%h want 32/00",
               eop_pos, eop_byte);
    end
    vec++;
    if (mac_bad != 0 || pay_early != 0) begin
      errs++;
      $display("FAIL csum_mac_payrdy: got %0d %0d want 0 0",
               mac_bad, pay_early);
    end
  endtask

  task automatic test_rejection();
    bit ok;
    int w;
    int vld_seen;
    logic [7:0] got;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      set_req(32'hC0A80101, (r == 0) ? 11'd0 : 11'd123);
      wait_accept(ok, w);
      req_vld = 1'b0;
      #3;
      vec++;
      if (!ok || req_err !== 1'b1) begin
        errs++;
        $display("FAIL rej_err[%0d]: got %b want 1", r, req_err);
      end
      step();
      #3;
      vec++;
      if (req_err !== 1'b0) begin
        errs++;
        $display("FAIL rej_pulse[%0d]: got %b want 0", r, req_err);
      end
      vld_seen = 0;
      for (int c = 0; c < 16; c++) begin
        step();
        #3;
        if (eth_byte_vld) vld_seen++;
      end
      vec++;
      if (vld_seen != 0) begin
        errs++;
        $display("FAIL rej_quiet[%0d]: got %0d want 0", r, vld_seen);
      end
      step();
    end
    set_req(32'hC0A80101, 11'd4);
    wait_accept(ok, w);
    req_vld = 1'b0;
    run_frame(4, 1'b0, ok);
    for (int i = 0; i < 32; i++) begin
      got = (i < cap.size()) ? cap[i] : 8'hxx;
      vec++;
      if (got !== hand[i]) begin
        errs++;
        $display("FAIL rej_frame[%0d]: got %h want %h",
                 i, got, hand[i]);
      end
    end
  endtask

  task automatic test_max_len();
    bit ok;
    int w;
    logic [7:0] got;
    logic [7:0] want;
    pay_base = 8'h30;
    set_req(32'hC0A80101, 11'd122);
    wait_accept(ok, w);
    req_vld = 1'b0;
    run_frame(122, 1'b0, ok);
    vec++;
    if (!ok || cap.size() != 150 || eop_pos != 150) begin
      errs++;
      $display("FAIL max_size: got %0d eop %0d want 150 150",
               cap.size(), eop_pos);
    end
    vec++;
    if (cap.size() >= 28 &&
        {cap[2], cap[3], cap[4], cap[5], cap[10], cap[11],
         cap[24], cap[25]} !== 64'h0096_0001_B6FA_0082) begin
      errs++;
      $display("FAIL max_hdr: got %h want 00960001b6fa0082",
               {cap[2], cap[3], cap[4], cap[5], cap[10], cap[11],
                cap[24], cap[25]});
    end
    for (int i = 0; i < 122; i++) begin
      want = pay_base + 8'(i);
      got = (28 + i < cap.size()) ? cap[28 + i] : 8'hxx;
      vec++;
      if (got !== want) begin
        errs++;
        $display("FAIL max_pay[%0d]: got %h want %h", i, got, want);
      end
    end
    pay_base = 8'h11;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int w;
    do_reset();
    set_req(32'hC0A80101, 11'd4);
    wait_accept(ok, w);
    run_frame(4, 1'b0, ok);
    vec++;
    if (!ok || rdy_early != 0) begin
      errs++;
      $display("FAIL b2b_rdy_early: got %0d want 0", rdy_early);
    end
    vec++;
    if (cap.size() < 12 ||
        {cap[4], cap[5], cap[10], cap[11]} !== 32'h0000_B771) begin
      errs++;
      $display("FAIL b2b_first: got size %0d want ident 0000 csum b771",
               cap.size());
    end
    wait_accept(ok, w);
    req_vld = 1'b0;
    vec++;
    if (!ok || w != 0) begin
      errs++;
      $display("FAIL b2b_accept: got wait %0d want 0", w);
    end
    run_frame(4, 1'b0, ok);
    vec++;
    if (!ok || cap.size() != 32 ||
        {cap[4], cap[5], cap[10], cap[11]} !== 32'h0001_B770) begin
      errs++;
      $display("FAIL b2b_second: got size %0d want ident 0001 csum b770",
               cap.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int w;
    logic [7:0] got;
    do_reset();
    set_req(32'hC0A80101, 11'd4);
    wait_accept(ok, w);
    req_vld = 1'b0;
    run_frame(4, 1'b1, ok);
    vec++;
    if (!ok || cap.size() != 32) begin
      errs++;
      $display("FAIL bp_size: got %0d want 32", cap.size());
    end
    for (int i = 0; i < 32; i++) begin
      got = (i < cap.size()) ? cap[i] : 8'hxx;
      vec++;
      if (got !== hand[i]) begin
        errs++;
        $display("FAIL bp_byte[%0d]: got %h want %h",
                 i, got, hand[i]);
      end
    end
    vec++;
    if (unstable != 0 || pay_early != 0) begin
      errs++;
      $display("FAIL bp_stable: got %0d %0d want 0 0",
               unstable, pay_early);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int w;
    bit found;
    logic [7:0] got;
    do_reset();
    set_req(32'hC0A80101, 11'd4);
    wait_accept(ok, w);
    req_vld = 1'b0;
    pay_vld = 1'b1;
    pay_byte = 8'h5A;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      pay_vld = (c < 32) ? 1'b0 : 1'b1;
      #3;
      if (pay_rdy) found = 1'b1;
      else step();
    end
    vec++;
    if (!found) begin
      errs++;
      $display("FAIL rst_mid_pay: got no PAY want PAY");
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if ({req_rdy, pay_rdy, eth_byte_vld, eth_sop, eth_eop} !== 5'b0 ||
        eth_tx_byte !== 8'h00 || dst_mac !== 48'h0) begin
      errs++;
      $display("FAIL rst_mid_out: got %b %h %h want 0",
               {req_rdy, pay_rdy, eth_byte_vld, eth_sop, eth_eop},
               eth_tx_byte, dst_mac);
    end
    pay_vld = 1'b0;
    step();
    rst_n = 1'b1;
    #3;
    vec++;
    if (req_rdy !== 1'b1) begin
      errs++;
      $display("FAIL rst_mid_idle: got %b want 1", req_rdy);
    end
    step();
    set_req(32'hC0A80101, 11'd4);
    wait_accept(ok, w);
    req_vld = 1'b0;
    run_frame(4, 1'b0, ok);
    for (int i = 0; i < 32; i++) begin
      got = (i < cap.size()) ? cap[i] : 8'hxx;
      vec++;
      if (got !== hand[i]) begin
        errs++;
        $display("FAIL rst_mid_frame[%0d]: got %h want %h",
                 i, got, hand[i]);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int w;
    do_reset();
    force dut.ident = 16'hFFFF;
    #1;
    release dut.ident;
    for (int f = 0; f < 2; f++) begin
      set_req(32'hC0A80101, 11'd4);
      wait_accept(ok, w);
      req_vld = 1'b0;
      run_frame(4, 1'b0, ok);
      vec++;
      if (!ok || cap.size() != 32 ||
          {cap[4], cap[5], cap[10], cap[11]} !==
          ((f == 0) ? 32'hFFFF_B771 : 32'h0000_B771)) begin
        errs++;
        $display("FAIL wrap[%0d]: got size %0d want ident %s",
                 f, cap.size(), (f == 0) ? "ffff" : "0000");
      end
    end
  endtask

  initial begin
    req_vld      = 1'b0;
    req_dst_ip   = '0;
    req_dst_mac  = '0;
    req_src_port = '0;
    req_dst_port = '0;
    req_len      = '0;
    pay_byte     = '0;
    pay_vld      = 1'b0;
    eth_byte_rdy = 1'b1;
    pay_base     = 8'h11;
    exp_mac      = 48'h02AB_CDEF_0102;
    hand = '{8'h45, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h40, 8'h00,
             8'h40, 8'h11, 8'hB7, 8'h71, 8'hC0, 8'hA8, 8'h01, 8'h0A,
             8'hC0, 8'hA8, 8'h01, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78,
             8'h00, 8'h0C, 8'h00, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14};
    test_reset();
    test_csum_frame();
    test_rejection();
    test_max_len();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
